maze_generator: RTL and testbench
=================================

Name: maze_generator

Overview:
- Generates a random perfect maze (exactly one path between any two open cells) in the same wall/open array format that the maze solver consumes.
- Encoding: 1 = wall, 0 = open.
- Entry is on row 0; exit is on row size-1.
- Uses a randomized depth-first backtracker, an explicit cell stack and a 16-bit LFSR, so the solver can be fed many mazes in simulation.

Parameters:
- size, 9, maze edge length in grid squares; odd, >= 5.
- N, 4, coordinate width; must satisfy 2^N >= size.
- CELLS, ((size-1)/2)**2, number of carvable cells (derived; 16 at default).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; begins generation when idle or done
- seed  input  16  LFSR seed, sampled on accepted start
- busy  output  1  high while generating
- done  output  1  high when maze is complete and stable
- maze  output  size x [size-1:0]  unpacked rows; maze[y][x]

Behaviour:
- Reset and clock: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: every maze row = all ones; busy=0; done=0; stack pointer sp=0; state IDLE. Reset mid-generation aborts immediately to these values.
- Cell squares are at odd (x,y). Cell (cx,cy) maps to square (2cx+1, 2cy+1). Walls between cells sit at even offsets.
- States: IDLE, FILL, INIT, STEP, OPEN, DONE.
- IDLE / DONE:
  - start=1 loads lfsr<=seed; a seed of 0 is replaced by 16'hACE1.
  - Clears row counter, sets busy=1, done=0, goes to FILL.
  - start while busy is ignored.
- FILL: writes maze[row] = all ones, one row per cycle, for size cycles, then goes to INIT.
- INIT:
  - Clears maze[1][1].
  - Pushes cell (0,0); sp=1.
  - Goes to STEP.
- STEP (one action per cycle; lfsr advances every STEP cycle):
  - Take the top-of-stack cell. Neighbour candidates, indexed LEFT=0, RIGHT=1, DOWN=2, UP=3.
  - A candidate is valid if it is in bounds and its square still reads 1 (unvisited).
  - Selection: scan from index lfsr[1:0] upward mod 4; the first valid candidate wins.
  - If a candidate is found: clear the wall square between the two cells and the neighbour square, then push the neighbour.
  - If none is found: pop. If sp becomes 0, go to OPEN.
  - STEP lasts exactly 2*CELLS-1 cycles: CELLS-1 carves plus CELLS pops.
- OPEN:
  - Clears entry maze[0][1] and exit maze[size-1][size-2].
  - Then sets done=1, busy=0, goes to DONE.
- DONE: maze holds constant until the next accepted start or rst.
- Latency: done rises size + 2*CELLS + 1 cycles after the start edge (42 at default).
- Stack:
  - CELLS entries of packed {cy,cx}.
  - Never overflows, because every cell is pushed once.
  - A pop at sp=0 cannot occur.
- LFSR: Galois, taps mask 16'hB400, shift right, never reaches 0.
- Result: exactly CELLS + (CELLS-1) + 2 zeros in maze (33 at default). Border is all walls except entry and exit.

Optional Feature:
- Macro MAZE_GEN_STEP_EN.
- Defined: adds input step (1 bit). STEP state acts, and the LFSR advances, only on cycles with step=1; otherwise STEP holds. Used for single-stepping and animation.
- Undefined: no step port; STEP acts every cycle as above.
- FILL, INIT and OPEN are unaffected in both cases.

Decomposition:
- Shared package maze_pkg holds:
  - Direction enum LEFT, RIGHT, DOWN, UP, NONE; same encoding the solver uses.
  - Generator state enum.
  - LFSR_TAPS = 16'hB400.
  - DEFAULT_SEED = 16'hACE1.
- Sub-module maze_lfsr: 16-bit Galois LFSR with inputs load, seed, advance and output q. Substitutes the default seed on zero.

Test Plan:
- Reset: assert rst for 2 cycles -> busy=0, done=0, all 81 maze bits=1; re-assert rst mid-STEP -> same values next cycle.
- seed=16'h1234, single start pulse -> busy rises next cycle; done rises exactly 42 cycles after the start edge. maze[0][1]=0, maze[8][7]=0, 33 zeros total, all other border bits 1, every odd (x,y) = 0.
- Same seed 16'h1234 run twice -> bit-identical mazes. seed=0 and seed=16'hACE1 -> identical mazes.
- Start pulses during busy -> ignored; done timing unchanged at 42.
- Connectivity: feed a finished maze to the solver -> solver reaches done, and its path includes (1,0) and (7,8).
- With MAZE_GEN_STEP_EN: step held 0 after INIT -> maze frozen. Pulse step 31 times -> OPEN reached; done after one more cycle.

Source files
------------

// File: rtl/maze_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : maze_pkg                                                  |
// | Purpose  : Types and constants shared by the maze generator, its     |
// |            LFSR and the maze solver.                                 |
// | Contents : dir_e       - neighbour direction, same encoding as the   |
// |                          solver (LEFT=0, RIGHT=1, DOWN=2, UP=3)      |
// |            gen_state_e - generator FSM states                        |
// |            LFSR_TAPS   - Galois feedback mask (shift right)          |
// |            DEFAULT_SEED- replaces a zero seed                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package maze_pkg;

  typedef enum logic [2:0] {
    LEFT  = 3'd0,
    RIGHT = 3'd1,
    DOWN  = 3'd2,
    UP    = 3'd3,
    NONE  = 3'd4
  } dir_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_INIT = 3'd2,
    S_STEP = 3'd3,
    S_OPEN = 3'd4,
    S_DONE = 3'd5
  } gen_state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage : maze_pkg
`default_nettype wire

// File: rtl/maze_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : maze_lfsr                                                 |
// | Purpose  : 16-bit Galois LFSR (right shift, taps LFSR_TAPS). A zero   |
// |            seed is replaced by DEFAULT_SEED so the register never     |
// |            locks up at zero.                                         |
// | Ports    : clk     in   clock                                        |
// |            rst     in   synchronous active-high reset                |
// |            load    in   load seed (has priority over advance)        |
// |            seed    in   16-bit seed value                            |
// |            advance in   shift one step                               |
// |            q       out  low QW bits of the LFSR state                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module maze_lfsr
  import maze_pkg::*;
#(
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [15:0]   seed,
  input  logic          advance,
  output logic [QW-1:0] q
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (advance) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q[QW-1:0];

endmodule : maze_lfsr
`default_nettype wire

// File: rtl/maze_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : maze_generator                                            |
// | Purpose  : Randomised depth-first backtracker producing a perfect    |
// |            maze (1 = wall, 0 = open). Entry at maze[0][1], exit at   |
// |            maze[SIZE-1][SIZE-2]. Cells sit at odd (x,y) squares.     |
// | Ports    : clk   in   clock                                          |
// |            rst   in   synchronous active-high reset                  |
// |            start in   begin generation (accepted in IDLE or DONE)    |
// |            seed  in   LFSR seed, sampled on accepted start           |
// |            step  in   (MAZE_GEN_STEP_EN only) STEP acts when high     |
// |            busy  out  high while generating                          |
// |            done  out  high when the maze is complete and stable      |
// |            maze  out  SIZE unpacked rows, maze[y][x]                 |
// | Options  : MAZE_GEN_STEP_EN adds the step input for single-stepping. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module maze_generator
  import maze_pkg::*;
#(
  parameter int SIZE  = 9,
  parameter int N     = 4,
  parameter int CELLS = ((SIZE - 1) / 2) ** 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     seed,
`ifdef MAZE_GEN_STEP_EN
  input  logic            step,
`endif
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] maze [SIZE]
);

  localparam int HALF = (SIZE - 1) / 2;          // cells per edge
  localparam int SPW  = $clog2(CELLS + 1);       // stack pointer width
  localparam int IW   = $clog2(CELLS);           // stack index width

  gen_state_e      state_q, state_d;
  logic [SIZE-1:0] maze_q [SIZE];
  logic [SIZE-1:0] maze_d [SIZE];
  logic [2*N-1:0]  stack_q [CELLS];
  logic [2*N-1:0]  stack_d [CELLS];
  logic [SPW-1:0]  sp_q, sp_d;
  logic [N-1:0]    row_q, row_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            w_load;
  logic            w_adv;
  logic            w_step_ok;
  logic [1:0]      w_rnd;
  logic [IW-1:0]   w_top_idx;
  logic [IW-1:0]   w_push_idx;
  logic [N-1:0]    w_cx, w_cy, w_sx, w_sy;
  logic [N-1:0]    w_nx [4];
  logic [N-1:0]    w_ny [4];
  logic [N-1:0]    w_wx [4];
  logic [N-1:0]    w_wy [4];
  logic [3:0]      w_inb;
  logic [3:0]      w_valid;
  logic [1:0]      w_sel;
  logic            w_found;
  dir_e            w_dir;

`ifdef MAZE_GEN_STEP_EN
  assign w_step_ok = step;
`else
  assign w_step_ok = 1'b1;
`endif

  maze_lfsr #(
    .QW (2)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (w_load),
    .seed    (seed),
    .advance (w_adv),
    .q       (w_rnd)
  );

  // Top-of-stack cell and its square coordinates (2c+1).
  assign w_top_idx  = IW'(sp_q - SPW'(1));
  assign w_push_idx = IW'(sp_q);
  assign w_cx       = stack_q[w_top_idx][N-1:0];
  assign w_cy       = stack_q[w_top_idx][2*N-1:N];
  assign w_sx       = {w_cx[N-2:0], 1'b1};
  assign w_sy       = {w_cy[N-2:0], 1'b1};

  // Neighbour and wall squares per direction; a neighbour square still
  // holding a 1 has never been visited.
  always_comb begin
    w_nx[0] = w_sx - 2'd2;  w_ny[0] = w_sy;          w_wx[0] = w_sx - 1'b1;  w_wy[0] = w_sy;
    w_nx[1] = w_sx + 2'd2;  w_ny[1] = w_sy;          w_wx[1] = w_sx + 1'b1;  w_wy[1] = w_sy;
    w_nx[2] = w_sx;         w_ny[2] = w_sy + 2'd2;   w_wx[2] = w_sx;         w_wy[2] = w_sy + 1'b1;
    w_nx[3] = w_sx;         w_ny[3] = w_sy - 2'd2;   w_wx[3] = w_sx;         w_wy[3] = w_sy - 1'b1;
    w_inb[0] = (w_cx != '0);
    w_inb[1] = (w_cx != N'(HALF - 1));
    w_inb[2] = (w_cy != N'(HALF - 1));
    w_inb[3] = (w_cy != '0);
    for (int d = 0; d < 4; d++) begin
      w_valid[d] = w_inb[d] ? maze_q[w_ny[d]][w_nx[d]] : 1'b0;
    end
  end

  // Rotating priority scan starting at the random index.
  always_comb begin
    w_found = 1'b0;
    w_sel   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && w_valid[w_rnd + 2'(k)]) begin
        w_found = 1'b1;
        w_sel   = w_rnd + 2'(k);
      end
    end
    w_dir = w_found ? dir_e'({1'b0, w_sel}) : NONE;
  end

  always_comb begin
    state_d = state_q;
    maze_d  = maze_q;
    stack_d = stack_q;
    sp_d    = sp_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = done_q;
    w_load  = 1'b0;
    w_adv   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_load  = 1'b1;
          row_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        maze_d[row_q] = '1;
        if (row_q == N'(SIZE - 1)) begin
          state_d = S_INIT;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_INIT: begin
        maze_d[1][1] = 1'b0;
        stack_d[0]   = '0;
        sp_d         = SPW'(1);
        state_d      = S_STEP;
      end
      S_STEP: begin
        if (w_step_ok) begin
          w_adv = 1'b1;
          if (w_dir != NONE) begin
            maze_d[w_wy[w_sel]][w_wx[w_sel]] = 1'b0;
            maze_d[w_ny[w_sel]][w_nx[w_sel]] = 1'b0;
            // Square (2c+1) >> 1 recovers the cell coordinate c.
            stack_d[w_push_idx] = {w_ny[w_sel] >> 1, w_nx[w_sel] >> 1};
            sp_d = sp_q + 1'b1;
          end else begin
            sp_d = sp_q - 1'b1;
            if (sp_q == SPW'(1)) begin
              state_d = S_OPEN;
            end
          end
        end
      end
      S_OPEN: begin
        maze_d[0][1]           = 1'b0;
        maze_d[SIZE-1][SIZE-2] = 1'b0;
        done_d                 = 1'b1;
        busy_d                 = 1'b0;
        state_d                = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int y = 0; y < SIZE; y++) begin
        maze_q[y] <= '1;
      end
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      maze_q  <= maze_d;
    end
  end

  // The stack holds no meaning outside STEP, so it needs no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign maze = maze_q;

endmodule : maze_generator
`default_nettype wire

// File: tb/tb_maze_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_maze_generator                                         |
// | Purpose  : Self-checking bench for maze_generator (default 9x9).     |
// |            Honours MAZE_GEN_STEP_EN when defined.                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_maze_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        busy;
  logic        done;
  logic [8:0]  maze [9];
`ifdef MAZE_GEN_STEP_EN
  logic        step = 1'b1;
`endif

  int passed = 0;
  int total  = 0;

  logic [8:0] exp_maze [9];
  logic [8:0] saved [9];

  always #5 clk = ~clk;

  maze_generator dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .seed  (seed),
`ifdef MAZE_GEN_STEP_EN
    .step  (step),
`endif
    .busy  (busy),
    .done  (done),
    .maze  (maze)
  );

  // Independent reference: randomized DFS backtracker on a 4x4 cell grid.
  task automatic model_gen(input logic [15:0] sd);
    logic [15:0] l;
    int scx [16];
    int scy [16];
    int sp, cx, cy, nx, ny, d, fx, fy;
    bit found;
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int y = 0; y < 9; y++) exp_maze[y] = 9'h1FF;
    exp_maze[1][1] = 1'b0;
    scx[0] = 0; scy[0] = 0; sp = 1;
    while (sp > 0) begin
      cx = scx[sp-1]; cy = scy[sp-1];
      found = 0; fx = 0; fy = 0;
      for (int k = 0; k < 4; k++) begin
        d = (int'(l[1:0]) + k) % 4;
        nx = cx; ny = cy;
        case (d)
          0: nx = cx - 1;
          1: nx = cx + 1;
          2: ny = cy + 1;
          default: ny = cy - 1;
        endcase
        if (!found && nx >= 0 && nx < 4 && ny >= 0 && ny < 4) begin
          if (exp_maze[2*ny+1][2*nx+1]) begin
            found = 1; fx = nx; fy = ny;
          end
        end
      end
      if (found) begin
        exp_maze[cy+fy+1][cx+fx+1] = 1'b0;
        exp_maze[2*fy+1][2*fx+1]   = 1'b0;
        scx[sp] = fx; scy[sp] = fy; sp++;
      end else begin
        sp--;
      end
      l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0);
    end
    exp_maze[0][1] = 1'b0;
    exp_maze[8][7] = 1'b0;
  endtask

  function automatic int count_zeros();
    int z = 0;
    for (int y = 0; y < 9; y++)
      for (int x = 0; x < 9; x++)
        if (maze[y][x] == 1'b0) z++;
    return z;
  endfunction

  function automatic int rows_differ_exp();
    int n = 0;
    for (int y = 0; y < 9; y++) if (maze[y] !== exp_maze[y]) n++;
    return n;
  endfunction

  function automatic int rows_differ_saved();
    int n = 0;
    for (int y = 0; y < 9; y++) if (maze[y] !== saved[y]) n++;
    return n;
  endfunction

  // Start one generation; lat = clock edges from the start edge to done.
  task automatic run_gen(input logic [15:0] sd, input bit spam,
                         output int lat, output logic busy_seen);
    @(negedge clk);
    start = 1'b1; seed = sd;
    @(negedge clk);
    start = 1'b0; seed = 16'h0BAD;
    busy_seen = busy;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      start = (spam && (lat % 5 == 2)) ? 1'b1 : 1'b0;
      if (spam) seed = 16'h5555;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (count_zeros() !== 0) $display("FAIL reset_maze_zeros: got %0d expected 0", count_zeros()); else passed++;
    rst = 1'b0;
  endtask

  task automatic check_structure(input string tag);
    int bad_border, odd_open, even_wall, reach, changed;
    bit vis [9][9];
    bad_border = 0; odd_open = 0; even_wall = 0;
    for (int y = 0; y < 9; y++)
      for (int x = 0; x < 9; x++) begin
        vis[y][x] = 1'b0;
        if ((y == 0 || y == 8 || x == 0 || x == 8) && !(y == 0 && x == 1) &&
            !(y == 8 && x == 7) && maze[y][x] !== 1'b1) bad_border++;
        if ((y % 2 == 1) && (x % 2 == 1) && maze[y][x] === 1'b0) odd_open++;
        if ((y % 2 == 0) && (x % 2 == 0) && maze[y][x] === 1'b1) even_wall++;
      end
    total++; if (maze[0][1] !== 1'b0) $display("FAIL %s_entry: got %b expected 0", tag, maze[0][1]); else passed++;
    total++; if (maze[8][7] !== 1'b0) $display("FAIL %s_exit: got %b expected 0", tag, maze[8][7]); else passed++;
    total++; if (count_zeros() !== 33) $display("FAIL %s_zeros: got %0d expected 33", tag, count_zeros()); else passed++;
    total++; if (bad_border !== 0) $display("FAIL %s_border: got %0d open border squares expected 0", tag, bad_border); else passed++;
    total++; if (odd_open !== 16) $display("FAIL %s_cells_open: got %0d expected 16", tag, odd_open); else passed++;
    total++; if (even_wall !== 25) $display("FAIL %s_pillars: got %0d expected 25", tag, even_wall); else passed++;
    // Flood fill from the entry; a perfect maze reaches every open square.
    vis[0][1] = (maze[0][1] === 1'b0);
    changed = 1;
    while (changed != 0) begin
      changed = 0;
      for (int y = 0; y < 9; y++)
        for (int x = 0; x < 9; x++)
          if (!vis[y][x] && maze[y][x] === 1'b0 &&
              ((y > 0 && vis[y-1][x]) || (y < 8 && vis[y+1][x]) ||
               (x > 0 && vis[y][x-1]) || (x < 8 && vis[y][x+1]))) begin
            vis[y][x] = 1'b1; changed++;
          end
    end
    reach = 0;
    for (int y = 0; y < 9; y++) for (int x = 0; x < 9; x++) if (vis[y][x]) reach++;
    total++; if (reach !== 33) $display("FAIL %s_reach: got %0d expected 33", tag, reach); else passed++;
    total++; if (vis[8][7] !== 1'b1) $display("FAIL %s_exit_reached: got %b expected 1", tag, vis[8][7]); else passed++;
  endtask

  task automatic test_generate(input logic [15:0] sd, input string tag);
    int lat; logic bs;
    run_gen(sd, 1'b0, lat, bs);
    total++; if (bs !== 1'b1) $display("FAIL %s_busy_rise: got %b expected 1", tag, bs); else passed++;
    total++; if (lat !== 42) $display("FAIL %s_latency: got %0d expected 42", tag, lat); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL %s_busy_done: got %b expected 0", tag, busy); else passed++;
    model_gen(sd);
    total++; if (rows_differ_exp() !== 0) $display("FAIL %s_model: got %0d differing rows expected 0", tag, rows_differ_exp()); else passed++;
  endtask

  task automatic test_basic();
    test_generate(16'h1234, "s1234");
    check_structure("s1234");
    repeat (5) @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL done_hold: got %b expected 1", done); else passed++;
    total++; if (rows_differ_exp() !== 0) $display("FAIL maze_hold: got %0d differing rows expected 0", rows_differ_exp()); else passed++;
  endtask

  task automatic test_back_to_back();
    saved = maze;
    test_generate(16'h1234, "repeat");
    total++; if (rows_differ_saved() !== 0) $display("FAIL repeat_identical: got %0d differing rows expected 0", rows_differ_saved()); else passed++;
  endtask

  task automatic test_seed_zero();
    test_generate(16'h0000, "seed0");
    saved = maze;
    test_generate(16'hACE1, "seedACE1");
    total++; if (rows_differ_saved() !== 0) $display("FAIL seed0_vs_ace1: got %0d differing rows expected 0", rows_differ_saved()); else passed++;
  endtask

  task automatic test_start_while_busy();
    int lat; logic bs;
    run_gen(16'h7A3C, 1'b1, lat, bs);
    total++; if (lat !== 42) $display("FAIL spam_latency: got %0d expected 42", lat); else passed++;
    model_gen(16'h7A3C);
    total++; if (rows_differ_exp() !== 0) $display("FAIL spam_model: got %0d differing rows expected 0", rows_differ_exp()); else passed++;
    check_structure("spam");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; seed = 16'hBEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);   // 20 edges after start: inside STEP
    total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", busy); else passed++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL mid_reset_done: got %b expected 0", done); else passed++;
    total++; if (count_zeros() !== 0) $display("FAIL mid_reset_zeros: got %0d expected 0", count_zeros()); else passed++;
    rst = 1'b0;
    test_generate(16'hBEEF, "after_reset");
  endtask

`ifdef MAZE_GEN_STEP_EN
  task automatic test_step();
    step = 1'b0;
    @(negedge clk);
    start = 1'b1; seed = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (count_zeros() !== 1) $display("FAIL step_frozen_zeros: got %0d expected 1", count_zeros()); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL step_frozen_busy: got %b expected 1", busy); else passed++;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
    end
    total++; if (done !== 1'b0) $display("FAIL step_done_early: got %b expected 0", done); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL step_done: got %b expected 1", done); else passed++;
    model_gen(16'h1234);
    total++; if (rows_differ_exp() !== 0) $display("FAIL step_model: got %0d differing rows expected 0", rows_differ_exp()); else passed++;
    step = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_seed_zero();
    test_start_while_busy();
    test_reset_mid();
`ifdef MAZE_GEN_STEP_EN
    test_step();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_maze_generator
`default_nettype wire
